decode_pipe_stage: RTL and testbench
====================================

Name: decode_pipe_stage

Overview:
Parametrised, fully registered RV32I decode stage between fetch and execute. It decodes the instruction, reads an internal register file, and selects one immediate by format. Operands are captured into a 2-entry output buffer (main + skid) with a valid/ready handshake on both sides. Adds flush, load-use hazard stall, and operand refresh for held entries.

Parameters:
XLEN, 32, data/register width
NREG, 32, architectural register count; x0 hardwired to zero
RA_W, 5, register index width, $clog2(NREG)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all buffered entries; block input this cycle
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage accepts; transfer = in_valid & in_ready
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
hz_valid  in  1  execute holds a load whose result is not yet available
hz_rd  in  RA_W  destination of that load
reg_load  in  1  writeback write enable
rd_sel  in  RA_W  writeback register index
rd_data  in  XLEN  writeback data
out_valid  out  1  main entry valid
out_ready  in  1  execute accepts; transfer = out_valid & out_ready
out_pc  out  XLEN  PC of main entry
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_rs1, out_rs2, out_rd  out  RA_W  instr[19:15], [24:20], [11:7]
out_rs1_data, out_rs2_data  out  XLEN  operand values
out_imm  out  XLEN  selected immediate

Behaviour:
- Reset: out_valid=0, skid empty, all out_* =0, all regfile entries=0. in_ready=0 during the rst cycle.
- Regfile: written on posedge when reg_load and rd_sel!=0. Reads of x0 return 0. Writes to x0 are ignored.
- Immediate select by opcode: LUI/AUIPC→U; JAL→J; BRANCH→B; STORE→S; LOAD/OP-IMM/JALR→I; all others→0. RV32I encodings are sign-extended to XLEN.
- Hazard: haz = hz_valid & hz_rd!=0 & (rs1==hz_rd | rs2==hz_rd) on in_instr. rs2 is compared only for OP/BRANCH/STORE.
- in_ready = !rst & !flush & !skid_valid & !haz.
- Latency: 1 cycle from accept to out_valid when the buffer is empty or draining.
- Buffer, per cycle:
  - Accept with main empty, or main transferring: load main.
  - Accept with main held (out_ready=0): load skid.
  - Main transferring and skid valid: skid→main, skid cleared.
  - Main transferring, no skid, no accept: out_valid→0.
- Held-entry refresh: on a regfile write, any valid main/skid entry with rsN==rd_sel!=0 replaces rsN_data with rd_data at the same edge. Main and skid are refreshed independently.
- Flush: at the edge, out_valid=0 and skid cleared. No accept happens in the flush cycle. The regfile write still occurs. flush has priority over rst-free transfers; rst has priority over everything.
- out_* fields hold stable while out_valid=1 and out_ready=0, except for refresh.
- Same-cycle write and accepted read of the same register: see feature.

Optional Feature:
DECODE_BYPASS_EN. Defined: an accepted instruction reading rd_sel while reg_load=1 and rd_sel!=0 captures rd_data (write-through). Undefined: it captures the pre-write regfile value. The integrating pipeline must then avoid same-cycle RAW, e.g. by stalling via hz_*. Refresh of already-held entries happens in both builds.

Test Plan:
- Reset, then write x5=0x1234, then accept ADDI x6,x5,-1 (0xFFF28313) → next cycle out_valid=1, out_rs1_data=0x1234, out_imm=0xFFFFFFFF, out_rd=6.
- Hold out_ready=0 and offer 3 back-to-back instrs → first in main, second in skid, in_ready=0 on the third. Raise out_ready → issued in order, 1 per cycle, none lost or duplicated.
- hz_valid=1, hz_rd=7; offer ADD x1,x7,x2 → in_ready=0. Drop hz_valid → accepted next cycle. With hz_rd=7 and offer LUI x7,0x12345 → accepted, out_imm=0x12345000.
- Hold ADD x3,x4,x5 in main (out_ready=0); write x4=0xDEAD → out_rs1_data becomes 0xDEAD the next cycle. Write x0=5 → x0 reads remain 0.
- Main+skid full, assert flush with in_valid=1 → next cycle out_valid=0, skid empty, input not accepted.
- Same cycle: reg_load x9=0xBEEF and accept ADD x1,x9,x0 → out_rs1_data=0xBEEF with DECODE_BYPASS_EN, old x9 value without it.

Source files
------------

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: RV32I decode with regfile, immediate select, main+skid output buffer (option DECODE_BYPASS_EN)
module decode_pipe_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int RA_W = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            hz_valid,
   input  logic [RA_W-1:0] hz_rd,
   input  logic            reg_load,
   input  logic [RA_W-1:0] rd_sel,
   input  logic [XLEN-1:0] rd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [RA_W-1:0] out_rs1,
   output logic [RA_W-1:0] out_rs2,
   output logic [RA_W-1:0] out_rd,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm
);
   typedef struct packed {
      logic            v;
      logic [XLEN-1:0] pc;
      logic [31:0]     ins;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic [XLEN-1:0] imm;
   } ent_t;

   logic [XLEN-1:0] rf [NREG];
   ent_t main_q, skid_q, main_r, skid_r, new_e;
   logic [6:0] op;
   logic [RA_W-1:0] rs1, rs2;
   logic [31:0] imm32;
   logic [XLEN-1:0] r1, r2;
   logic use_rs2, haz, acc, wr, byp1, byp2;

   assign op = in_instr[6:0];
   assign rs1 = RA_W'(in_instr[19:15]);
   assign rs2 = RA_W'(in_instr[24:20]);
   assign wr = reg_load && rd_sel != '0;

   assign imm32 = (op == 7'h37 || op == 7'h17) ? {in_instr[31:12], 12'b0} :
                  (op == 7'h6F) ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                  (op == 7'h63) ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                  (op == 7'h23) ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                  (op == 7'h03 || op == 7'h13 || op == 7'h67) ? {{20{in_instr[31]}}, in_instr[31:20]} : '0;

`ifdef DECODE_BYPASS_EN
   assign byp1 = wr && rd_sel == rs1;
   assign byp2 = wr && rd_sel == rs2;
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   assign r1 = (rs1 == '0) ? '0 : byp1 ? rd_data : rf[rs1];
   assign r2 = (rs2 == '0) ? '0 : byp2 ? rd_data : rf[rs2];
   assign new_e = {1'b1, in_pc, in_instr, r1, r2, XLEN'($signed(imm32))};

   assign use_rs2 = op == 7'h33 || op == 7'h63 || op == 7'h23;
   assign haz = hz_valid && hz_rd != '0 && (rs1 == hz_rd || (use_rs2 && rs2 == hz_rd));
   assign in_ready = !rst && !flush && !skid_q.v && !haz;
   assign acc = in_valid && in_ready;

   // Held entries pick up a same-edge writeback to the registers they read
   always_comb begin
      main_r = main_q;
      skid_r = skid_q;
      main_r.d1 = (wr && RA_W'(main_q.ins[19:15]) == rd_sel) ? rd_data : main_q.d1;
      main_r.d2 = (wr && RA_W'(main_q.ins[24:20]) == rd_sel) ? rd_data : main_q.d2;
      skid_r.d1 = (wr && RA_W'(skid_q.ins[19:15]) == rd_sel) ? rd_data : skid_q.d1;
      skid_r.d2 = (wr && RA_W'(skid_q.ins[24:20]) == rd_sel) ? rd_data : skid_q.d2;
   end

   // Register file; x0 never written so it stays zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wr) begin
         rf[rd_sel] <= rd_data;
      end
   end

   // Main/skid buffer: skid drains first, new entry goes to main when it frees, else to skid
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_q.v <= 1'b0;
         skid_q.v <= 1'b0;
      end else if (!main_q.v || out_ready) begin
         if (skid_q.v) main_q <= skid_r;
         else if (acc) main_q <= new_e;
         else main_q.v <= 1'b0;
         skid_q.v <= 1'b0;
      end else begin
         main_q <= main_r;
         skid_q <= acc ? new_e : skid_r;
      end
   end

   assign out_valid = main_q.v;
   assign out_pc = main_q.pc;
   assign out_opcode = main_q.ins[6:0];
   assign out_funct3 = main_q.ins[14:12];
   assign out_funct7 = main_q.ins[31:25];
   assign out_rs1 = RA_W'(main_q.ins[19:15]);
   assign out_rs2 = RA_W'(main_q.ins[24:20]);
   assign out_rd = RA_W'(main_q.ins[11:7]);
   assign out_rs1_data = main_q.d1;
   assign out_rs2_data = main_q.d2;
   assign out_imm = main_q.imm;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb_decode_pipe_stage: directed table and sequence checks for decode_pipe_stage
module tb_decode_pipe_stage;
   logic clk = 0, rst, flush, in_valid, in_ready, hz_valid, reg_load, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, rd_data, out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [4:0] hz_rd, rd_sel, out_rs1, out_rs2, out_rd;
   logic [6:0] out_opcode, out_funct7;
   logic [2:0] out_funct3;
   int total = 0, bad = 0;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [31:0] d1;
      logic [31:0] d2;
   } vec_t;
   vec_t vt [10];

`ifdef DECODE_BYPASS_EN
   localparam logic [31:0] X9_EXP = 32'hBEEF;
`else
   localparam logic [31:0] X9_EXP = 32'h1111;
`endif

   decode_pipe_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .hz_valid(hz_valid), .hz_rd(hz_rd),
      .reg_load(reg_load), .rd_sel(rd_sel), .rd_data(rd_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, a, e);
      end
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1;
      in_instr = ins;
      in_pc = pc;
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      reg_load = 1;
      rd_sel = a;
      rd_data = d;
      tick;
      reg_load = 0;
   endtask

   initial begin
      vt[0] = {32'h123453B7, 32'h12345000, 5'd7, 32'h0, 32'h0};
      vt[1] = {32'hFFFFF097, 32'hFFFFF000, 5'd1, 32'h0, 32'h0};
      vt[2] = {32'hFFDFF0EF, 32'hFFFFFFFC, 5'd1, 32'h0, 32'h0};
      vt[3] = {32'h00028463, 32'h00000008, 5'd8, 32'h1234, 32'h0};
      vt[4] = {32'hFE502C23, 32'hFFFFFFF8, 5'd24, 32'h0, 32'h1234};
      vt[5] = {32'h7FF2A183, 32'h000007FF, 5'd3, 32'h1234, 32'h0};
      vt[6] = {32'h005280B3, 32'h00000000, 5'd1, 32'h1234, 32'h1234};
      vt[7] = {32'h800280E7, 32'hFFFFF800, 5'd1, 32'h1234, 32'h0};
      vt[8] = {32'h40028133, 32'h00000000, 5'd2, 32'h1234, 32'h0};
      vt[9] = {32'hFFF00073, 32'h00000000, 5'd0, 32'h0, 32'h0};
      rst = 1; flush = 0; in_valid = 1; in_instr = 32'h13; in_pc = 0; hz_valid = 0; hz_rd = 0;
      reg_load = 0; rd_sel = 0; rd_data = 0; out_ready = 1;
      tick; tick;
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_imm", out_imm, 0);
      rst = 0; in_valid = 0;
      tick;
      chk("idle_out_valid", {31'b0, out_valid}, 0);

      // basic ADDI x6,x5,-1
      wr(5'd5, 32'h1234);
      offer(32'hFFF28313, 32'h100);
      chk("addi_in_ready", {31'b0, in_ready}, 1);
      tick;
      in_valid = 0;
      chk("addi_valid", {31'b0, out_valid}, 1);
      chk("addi_rs1_data", out_rs1_data, 32'h1234);
      chk("addi_imm", out_imm, 32'hFFFFFFFF);
      chk("addi_rd", {27'b0, out_rd}, 6);
      chk("addi_rs1", {27'b0, out_rs1}, 5);
      chk("addi_pc", out_pc, 32'h100);
      tick;
      chk("addi_drain", {31'b0, out_valid}, 0);

      // decode table, streaming one per cycle
      for (int i = 0; i < 10; i++) begin
         offer(vt[i].ins, 32'h200 + 4 * i);
         chk($sformatf("tab%0d_ready", i), {31'b0, in_ready}, 1);
         tick;
         chk($sformatf("tab%0d_valid", i), {31'b0, out_valid}, 1);
         chk($sformatf("tab%0d_pc", i), out_pc, 32'h200 + 4 * i);
         chk($sformatf("tab%0d_imm", i), out_imm, vt[i].imm);
         chk($sformatf("tab%0d_rd", i), {27'b0, out_rd}, {27'b0, vt[i].rd});
         chk($sformatf("tab%0d_d1", i), out_rs1_data, vt[i].d1);
         chk($sformatf("tab%0d_d2", i), out_rs2_data, vt[i].d2);
         chk($sformatf("tab%0d_op", i), {25'b0, out_opcode}, {25'b0, vt[i].ins[6:0]});
         chk($sformatf("tab%0d_f3", i), {29'b0, out_funct3}, {29'b0, vt[i].ins[14:12]});
         chk($sformatf("tab%0d_f7", i), {25'b0, out_funct7}, {25'b0, vt[i].ins[31:25]});
      end
      in_valid = 0;
      tick;
      chk("tab_drain", {31'b0, out_valid}, 0);

      // back-pressure: main, skid, then stall
      out_ready = 0;
      offer(32'h00100013, 32'h10); tick;
      offer(32'h00200013, 32'h14); tick;
      offer(32'h00300013, 32'h18);
      chk("bp_third_blocked", {31'b0, in_ready}, 0);
      tick;
      chk("bp_main_pc", out_pc, 32'h10);
      chk("bp_main_imm", out_imm, 32'h1);
      out_ready = 1;
      tick;
      chk("bp_2nd_pc", out_pc, 32'h14);
      chk("bp_2nd_imm", out_imm, 32'h2);
      tick;
      in_valid = 0;
      chk("bp_3rd_pc", out_pc, 32'h18);
      chk("bp_3rd_imm", out_imm, 32'h3);
      tick;
      chk("bp_drain", {31'b0, out_valid}, 0);

      // load-use hazard
      hz_valid = 1; hz_rd = 7;
      offer(32'h002380B3, 32'h40);
      chk("hz_rs1_block", {31'b0, in_ready}, 0);
      tick;
      chk("hz_not_taken", {31'b0, out_valid}, 0);
      hz_rd = 2; #1;
      chk("hz_rs2_block", {31'b0, in_ready}, 0);
      hz_valid = 0; #1;
      chk("hz_release", {31'b0, in_ready}, 1);
      tick;
      in_valid = 0;
      chk("hz_taken", {31'b0, out_valid}, 1);
      chk("hz_taken_rs1", {27'b0, out_rs1}, 7);
      tick;
      hz_valid = 1; hz_rd = 7;
      offer(32'h123453B7, 32'h44);
      chk("hz_lui_ready", {31'b0, in_ready}, 1);
      tick;
      chk("hz_lui_imm", out_imm, 32'h12345000);
      hz_rd = 2;
      offer(32'h00218093, 32'h48);
      chk("hz_opimm_rs2_ignored", {31'b0, in_ready}, 1);
      tick;
      chk("hz_opimm_pc", out_pc, 32'h48);
      hz_rd = 0;
      offer(32'h00100093, 32'h4C);
      chk("hz_x0_ready", {31'b0, in_ready}, 1);
      in_valid = 0; hz_valid = 0;
      tick;
      chk("hz_drain", {31'b0, out_valid}, 0);

      // refresh of held main and skid entries
      out_ready = 0;
      offer(32'h005201B3, 32'h60); tick;
      in_valid = 0;
      chk("rf_main_pre", out_rs1_data, 0);
      chk("rf_main_rs2", out_rs2_data, 32'h1234);
      wr(5'd4, 32'hDEAD);
      chk("rf_main_refresh", out_rs1_data, 32'hDEAD);
      chk("rf_main_held_pc", out_pc, 32'h60);
      wr(5'd0, 32'h5);
      chk("rf_x0_write_ignored", out_rs1_data, 32'hDEAD);
      offer(32'h00030093, 32'h64); tick;
      in_valid = 0;
      wr(5'd6, 32'h66);
      out_ready = 1;
      tick;
      chk("rf_skid_pc", out_pc, 32'h64);
      chk("rf_skid_refresh", out_rs1_data, 32'h66);
      offer(32'h00000093, 32'h68); tick;
      in_valid = 0;
      chk("rf_x0_read", out_rs1_data, 0);
      tick;

      // flush with full buffer and a concurrent regfile write
      out_ready = 0;
      offer(32'h00100013, 32'h80); tick;
      offer(32'h00200013, 32'h84); tick;
      offer(32'h00300013, 32'h88);
      flush = 1; reg_load = 1; rd_sel = 10; rd_data = 32'hA0A0; #1;
      chk("fl_in_ready", {31'b0, in_ready}, 0);
      tick;
      flush = 0; reg_load = 0; in_valid = 0;
      chk("fl_out_valid", {31'b0, out_valid}, 0);
      out_ready = 1;
      tick;
      chk("fl_skid_empty", {31'b0, out_valid}, 0);
      offer(32'h00050093, 32'h8C); tick;
      in_valid = 0;
      chk("fl_reg_written", out_rs1_data, 32'hA0A0);
      chk("fl_new_pc", out_pc, 32'h8C);
      tick;

      // same-cycle write and read of x9
      wr(5'd9, 32'h1111);
      reg_load = 1; rd_sel = 9; rd_data = 32'hBEEF;
      offer(32'h000480B3, 32'h90);
      tick;
      reg_load = 0; in_valid = 0;
      chk("byp_rs1_data", out_rs1_data, X9_EXP);
      tick;
      offer(32'h000480B3, 32'h94); tick;
      in_valid = 0;
      chk("byp_after_write", out_rs1_data, 32'hBEEF);

      // reset clears buffer and regfile
      rst = 1; tick; rst = 0;
      chk("rst2_out_valid", {31'b0, out_valid}, 0);
      chk("rst2_out_pc", out_pc, 0);
      offer(32'hFFF28313, 32'hA0); tick;
      in_valid = 0;
      chk("rst2_x5_cleared", out_rs1_data, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
